// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch initiator with prefetch FIFO, redirect flush and misalignment trap
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned PC_STEP  = 4,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        misalign_err,
  output logic [31:0] fetch_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {RUN, HALT} state_t;

  state_t             state;
  logic [31:0]        fetch_pc;
  logic [31:0]        instr_mem [DEPTH];
  logic [31:0]        pc_mem    [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  logic               deq;
  logic               enq;
  logic               room;
  logic               redirect_ok;
  logic               redirect_bad;
  logic [PTR_W-1:0]   rd_ptr_next;
  logic [CNT_W-1:0]   count_after_deq;
  logic [CNT_W-1:0]   count_next;

  assign imem_addr = fetch_pc;

  always_comb begin
    deq             = out_valid & out_ready;
    room            = (count < CNT_W'(DEPTH)) | deq;
    enq             = (state == RUN) & fetch_en & ~redirect_valid & room;
    redirect_ok     = (state == RUN) & redirect_valid & (redirect_pc[1:0] == 2'b00);
    redirect_bad    = (state == RUN) & redirect_valid & (redirect_pc[1:0] != 2'b00);
    rd_ptr_next     = rd_ptr + PTR_W'(deq);
    count_after_deq = count - CNT_W'(deq);
    count_next      = count_after_deq + CNT_W'(enq);
  end

  // Storage needs no reset: only entries covered by count are ever presented.
  always_ff @(posedge clk) begin
    if (enq) begin
      instr_mem[wr_ptr] <= imem_data;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= RUN;
      fetch_pc     <= RESET_PC;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid    <= 1'b0;
      out_instr    <= 32'h0;
      out_pc       <= 32'h0;
      misalign_err <= 1'b0;
      fetch_count  <= 32'h0;
    end else if (redirect_ok || redirect_bad) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      if (redirect_ok) begin
        fetch_pc <= redirect_pc;
      end else begin
        state        <= HALT;
        misalign_err <= 1'b1;
      end
    end else if (state == RUN) begin
      if (enq) begin
        wr_ptr      <= wr_ptr + PTR_W'(1);
        fetch_pc    <= fetch_pc + 32'(PC_STEP);
        fetch_count <= fetch_count + 32'h1;
      end
      rd_ptr    <= rd_ptr_next;
      count     <= count_next;
      out_valid <= (count_next != '0);
      // The head register mirrors the entry that will sit at rd_ptr after this
      // edge; when the FIFO drains to empty that entry is the incoming word.
      if (count_after_deq == '0) begin
        if (enq) begin
          out_instr <= imem_data;
          out_pc    <= fetch_pc;
        end
      end else begin
        out_instr <= instr_mem[rd_ptr_next];
        out_pc    <= pc_mem[rd_ptr_next];
      end
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch initiator for the multicycle RISC-V CPU; drives the read port of the instruction memory.
- Holds the fetch PC and presents it as a byte address on imem_addr.
- Captures the combinationally returned word into a small prefetch FIFO, tagged with its PC.
- Hands {instruction, pc} to decode over a valid/ready handshake; supports branch/jump redirect with flush, fetch enable and misalignment trap.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- PC_STEP, 4, byte increment per sequential fetch.
- DEPTH, 2, prefetch FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- fetch_en  in  1  permits new fetches when high.
- imem_addr  out  32  byte address to instruction memory; equals fetch_pc register.
- imem_data  in  32  instruction word; valid in the same cycle as imem_addr (combinational memory).
- redirect_valid  in  1  taken branch/jump this cycle.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  instruction at FIFO head.
- out_pc  out  32  PC of out_instr.
- misalign_err  out  1  sticky trap flag.
- fetch_count  out  32  number of words enqueued since reset; wraps modulo 2^32.

Behaviour:
- Reset (reset=1 at a clock edge):
  - fetch_pc=RESET_PC; FIFO empty; out_valid=0; out_instr=0; out_pc=0; misalign_err=0; fetch_count=0; state=RUN.
  - Reset overrides every other input, including during redirect or a full FIFO.
- States:
  - RUN: normal operation.
  - HALT: entered on misalignment. Exit only via reset.
- Handshake:
  - deq = out_valid & out_ready.
  - enq = (state==RUN) & fetch_en & ~redirect_valid & (count<DEPTH | deq).
- Enqueue:
  - On enq, write {imem_data, fetch_pc} at the tail.
  - fetch_pc += PC_STEP, wrapping modulo 2^32.
  - fetch_count += 1.
- Latency:
  - A word enqueued at edge N is visible on out_* after edge N (out_valid=1 in cycle N+1).
  - With fetch_en=1 and out_ready held high, one instruction is delivered per cycle.
- FIFO boundaries:
  - Full with no deq: no enq; fetch_pc holds.
  - Full with deq: enq and deq in the same edge; count unchanged.
  - Empty: out_valid=0; out_instr/out_pc hold their last values (don't-care to decode).
  - Pointers wrap modulo DEPTH.
- Redirect (redirect_valid=1 in RUN):
  - redirect_pc[1:0]==0:
    - FIFO flushed (count=0, pointers reset); fetch_pc=redirect_pc; no enq in that cycle.
    - A deq in the same cycle is still considered consumed; the flush wins over the remaining contents.
    - out_valid=0 in the next cycle.
    - The first redirected word is enqueued one edge later, if fetch_en=1.
  - redirect_pc[1:0]!=0:
    - misalign_err=1; state=HALT; FIFO flushed; fetch_pc unchanged.
- HALT:
  - No enq; redirects ignored; out_valid=0.
  - imem_addr holds; misalign_err stays 1 until reset.
- fetch_en=0:
  - No enq; FIFO keeps draining to decode.
  - Redirect still applies.
- imem_data==0 is a normal word: enqueued and counted, with no special treatment.

Test Plan:
- Reset, then fetch_en=1, out_ready=1, imem model holding 0x01450533 at address 4 and 0x0140B103 at address 8:
  - out_pc sequence 0,4,8,12.
  - out_instr at pc 4 = 0x01450533, at pc 8 = 0x0140B103.
  - fetch_count=4 after 4 enqueues.
- Backpressure with out_ready=0 for 5 cycles after reset:
  - Exactly DEPTH=2 enqueues; fetch_pc=8; imem_addr stable at 8.
  - Raising out_ready delivers pc 0,4,8 in order with no loss or duplication.
- Full FIFO with simultaneous deq:
  - With count=2, out_ready=1 for one cycle.
  - Head pc 0 consumed; pc 8 enqueued in the same edge; count stays 2.
- Redirect to 0x40 while FIFO holds pcs 4,8:
  - out_valid=0 in the next cycle.
  - Following cycle: out_pc=0x40 with the imem word at 0x40.
  - pcs 4 and 8 never appear after the redirect.
- Misaligned redirect to 0x42:
  - misalign_err=1 and out_valid=0 from the next cycle.
  - A later aligned redirect is ignored; fetch_count stays frozen.
  - reset clears misalign_err and restarts fetching at RESET_PC.
- Reset asserted mid-stream with a full FIFO and redirect_valid=1 in the same cycle:
  - Next cycle: out_valid=0, imem_addr=RESET_PC, fetch_count=0.
